// File: rtl/pll_lock_supervisor.sv
// rPLL bring-up sequencer: pulses PLL reset, waits for and qualifies LOCK, then
// releases the acquisition-domain reset; retries on failure and faults after MAX_RETRIES.
module pll_lock_supervisor #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned RST_HOLD     = 8
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       relock_req_i,
    output logic       pll_reset_o,
    output logic       ready_o,
    output logic       dom_rst_n_o,
    output logic       fault_o,
    output logic [1:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    localparam int unsigned MAX_A = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int unsigned MAX_B = (RESET_CYCLES > RST_HOLD) ? RESET_CYCLES : RST_HOLD;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_QUALIFY,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [1:0]    retry_nxt;
    logic [7:0]    loss_nxt;
    logic          pll_reset_nxt, ready_nxt, dom_rst_n_nxt, fault_nxt;
    logic          fail;
    logic          lock_s1, lock_s;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_s1 <= pll_lock_i;
            lock_s  <= lock_s1;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RESET_PLL;
            count       <= '0;
            pll_reset_o <= 1'b1;
            ready_o     <= 1'b0;
            dom_rst_n_o <= 1'b0;
            fault_o     <= 1'b0;
            retry_cnt_o <= '0;
            loss_cnt_o  <= '0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            pll_reset_o <= pll_reset_nxt;
            ready_o     <= ready_nxt;
            dom_rst_n_o <= dom_rst_n_nxt;
            fault_o     <= fault_nxt;
            retry_cnt_o <= retry_nxt;
            loss_cnt_o  <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count + 1'b1;
        retry_nxt = retry_cnt_o;
        loss_nxt  = loss_cnt_o;
        fail      = 1'b0;

        case (state)
            S_RESET_PLL: begin
                if (count == RESET_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s)                     state_nxt = S_QUALIFY;
                else if (count == TIMEOUT_LAST) fail      = 1'b1;
            end
            S_QUALIFY: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (count == STABLE_LAST) begin
                    state_nxt = S_RUN;
                    retry_nxt = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_RESET_PLL;
                    retry_nxt = '0;
                    if (loss_cnt_o != 8'hFF) loss_nxt = loss_cnt_o + 8'd1;
                end else if (count == HOLD_LAST) begin
                    count_nxt = count;
                end
            end
            S_FAULT: begin
                count_nxt = count;
            end
            default: begin
                state_nxt = S_RESET_PLL;
            end
        endcase

        if (fail) begin
            if (32'(retry_cnt_o) < MAX_RETRIES) begin
                retry_nxt = retry_cnt_o + 2'd1;
                state_nxt = S_RESET_PLL;
            end else begin
                state_nxt = S_FAULT;
            end
        end

        // relock overrides everything above, including a lock loss seen in the same cycle
        if (relock_req_i) begin
            state_nxt = S_RESET_PLL;
            retry_nxt = '0;
            loss_nxt  = loss_cnt_o;
        end

        if (state_nxt != state || relock_req_i) count_nxt = '0;

        pll_reset_nxt = (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
        ready_nxt     = (state_nxt == S_RUN);
        fault_nxt     = (state_nxt == S_FAULT);
        dom_rst_n_nxt = (state == S_RUN) && (state_nxt == S_RUN) && (count == HOLD_LAST);
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       relock_req_i = 1'b0;
    logic       pll_reset_o, ready_o, dom_rst_n_o, fault_o;
    logic [1:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;
    logic [13:0] obs;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .LOCK_STABLE (8),
        .MAX_RETRIES (2),
        .RST_HOLD    (3)
    ) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .pll_lock_i  (pll_lock_i),
        .relock_req_i(relock_req_i),
        .pll_reset_o (pll_reset_o),
        .ready_o     (ready_o),
        .dom_rst_n_o (dom_rst_n_o),
        .fault_o     (fault_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o)
    );

    always #5 clkin = ~clkin;

    assign obs = {pll_reset_o, ready_o, dom_rst_n_o, fault_o, retry_cnt_o, loss_cnt_o};

    typedef struct {
        int          n;
        logic        rst_n;
        logic        lock;
        logic        relock;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input int n, input logic r, input logic l, input logic q,
                                input logic pll, input logic rdy, input logic dom, input logic flt,
                                input logic [1:0] retry, input logic [7:0] loss);
        vec_t v;
        v.n = n; v.rst_n = r; v.lock = l; v.relock = q;
        v.exp = {pll, rdy, dom, flt, retry, loss};
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int guard;
        logic exp_pll, exp_flt;
        logic [1:0] exp_retry;

        // nominal bring-up, then lock loss in RUN and re-lock
        tbl[0]  = mk(3,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(3,  1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(6,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(10, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1,  1, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(2,  1, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(1,  1, 1, 0, 0, 1, 1, 0, 0, 0);
        tbl[8]  = mk(5,  1, 1, 0, 0, 1, 1, 0, 0, 0);
        tbl[9]  = mk(2,  1, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(1,  1, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[11] = mk(3,  1, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[12] = mk(1,  1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[13] = mk(10, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[14] = mk(1,  1, 1, 0, 0, 1, 0, 0, 0, 1);
        tbl[15] = mk(3,  1, 1, 0, 0, 1, 1, 0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            rst_n        = tbl[i].rst_n;
            pll_lock_i   = tbl[i].lock;
            relock_req_i = tbl[i].relock;
            tick(tbl[i].n);
            check($sformatf("vec[%0d]", i), 32'(obs), 32'(tbl[i].exp));
        end

        // no lock at all: three pulses, then FAULT
        pll_lock_i = 1'b0;
        rst_n = 1'b0;
        tick(2);
        check("noloc reset", 32'(obs), 32'(14'b1000_00_00000000));
        rst_n = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick(1);
            exp_pll   = (c < 4) || (c >= 24 && c < 28) || (c >= 48 && c < 52) || (c >= 72);
            exp_flt   = (c >= 72);
            exp_retry = (c < 24) ? 2'd0 : (c < 48) ? 2'd1 : 2'd2;
            check($sformatf("noloc c=%0d", c), 32'({pll_reset_o, ready_o, fault_o, retry_cnt_o}),
                  32'({exp_pll, 1'b0, exp_flt, exp_retry}));
        end
        relock_req_i = 1'b1;
        tick(1);
        relock_req_i = 1'b0;
        check("relock from fault", 32'({pll_reset_o, fault_o, retry_cnt_o}), 32'(4'b1000));
        tick(3);
        check("relock pulse high", 32'({pll_reset_o, fault_o}), 32'(2'b10));
        tick(1);
        check("relock pulse end", 32'({pll_reset_o, fault_o}), 32'(2'b00));

        // glitchy lock during QUALIFY, then a stable lock
        pll_lock_i = 1'b1;
        tick(5);
        pll_lock_i = 1'b0;
        tick(2);
        check("glitch qualify", 32'({pll_reset_o, ready_o, retry_cnt_o}), 32'(4'b0000));
        tick(1);
        check("glitch fail", 32'({pll_reset_o, ready_o, retry_cnt_o}), 32'(4'b1001));
        pll_lock_i = 1'b1;
        tick(12);
        check("glitch relock pre", 32'({ready_o, retry_cnt_o}), 32'(3'b001));
        tick(1);
        check("glitch relock run", 32'({ready_o, retry_cnt_o}), 32'(3'b100));

        // repeated losses saturate loss_cnt_o
        for (int i = 1; i <= 300; i++) begin
            pll_lock_i = 1'b0;
            tick(3);
            check($sformatf("loss %0d", i), 32'({ready_o, loss_cnt_o}),
                  32'({1'b0, (i >= 255) ? 8'd255 : 8'(i)}));
            pll_lock_i = 1'b1;
            guard = 0;
            while (!ready_o && guard < 40) begin
                tick(1);
                guard++;
            end
            check($sformatf("loss %0d relock", i), 32'(ready_o), 32'd1);
        end

        // relock coincident with final WAIT_LOCK timeout wins over FAULT
        pll_lock_i = 1'b0;
        guard = 0;
        while (!(retry_cnt_o == 2'd2 && !pll_reset_o && !fault_o) && guard < 200) begin
            tick(1);
            guard++;
        end
        check("prio reach retry2", 32'({retry_cnt_o, pll_reset_o}), 32'(3'b100));
        tick(19);
        check("prio pre-timeout", 32'({pll_reset_o, fault_o, retry_cnt_o}), 32'(4'b0010));
        relock_req_i = 1'b1;
        tick(1);
        relock_req_i = 1'b0;
        check("prio relock", 32'({pll_reset_o, fault_o, retry_cnt_o}), 32'(4'b1000));
        tick(3);
        check("prio pulse high", 32'({pll_reset_o, fault_o}), 32'(2'b10));
        tick(1);
        check("prio pulse end", 32'({pll_reset_o, fault_o}), 32'(2'b00));

        // async reset while in QUALIFY with retry and loss counts non-zero
        guard = 0;
        while (!(retry_cnt_o == 2'd1 && !pll_reset_o) && guard < 100) begin
            tick(1);
            guard++;
        end
        pll_lock_i = 1'b1;
        tick(5);
        check("areset pre", 32'(obs), 32'(14'b0000_01_11111111));
        #2;
        rst_n = 1'b0;
        #1;
        check("areset immediate", 32'(obs), 32'(14'b1000_00_00000000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
